// File: rtl/commit_trace_controller_pkg.sv
// Shared trace types for the commit trace path.
// Entry/record layouts, FSM states and accessors for C++ benches.
package commit_trace_controller_pkg;

    localparam int DEFAULT_COMMIT_WIDTH = 2;
    localparam int TRACE_SEQ_WIDTH = 16;
    localparam int DROP_CNT_WIDTH = 16;

    typedef struct packed {
        logic [9:0] sid;
        logic [1:0] mid;
    } OpId;

    typedef logic [31:0] PC_Path;
    typedef logic [4:0] LRegNumPath;

    typedef struct packed {
        OpId        opId;
        PC_Path     pc;
        logic       writeReg;
        LRegNumPath logDstRegNum;
    } CommitTraceEntry;

    typedef struct packed {
        logic [TRACE_SEQ_WIDTH-1:0] traceSeq;
        CommitTraceEntry            entry;
    } TraceRecord;

    typedef enum logic [1:0] {
        TRACE_DISABLED = 2'd0,
        TRACE_CAPTURE  = 2'd1,
        TRACE_DRAIN    = 2'd2
    } TraceCtrlState;

    function automatic logic [TRACE_SEQ_WIDTH-1:0] TraceRecord_traceSeq(
        TraceRecord r
    );
        return r.traceSeq;
    endfunction

    function automatic PC_Path TraceRecord_pc(TraceRecord r);
        return r.entry.pc;
    endfunction

    function automatic logic [9:0] TraceRecord_sid(TraceRecord r);
        return r.entry.opId.sid;
    endfunction

    function automatic LRegNumPath TraceRecord_logDstRegNum(TraceRecord r);
        return r.entry.logDstRegNum;
    endfunction

endpackage

// File: rtl/commit_trace_controller_if.sv
// Trace drain handshake between the controller and its consumer.
// The controller is the master; the debug/host side is the slave.
interface commit_trace_controller_if;
    import commit_trace_controller_pkg::*;

    logic       traceValid;
    logic       traceReady;
    TraceRecord traceData;

    modport master (
        output traceValid,
        output traceData,
        input  traceReady
    );

    modport slave (
        input  traceValid,
        input  traceData,
        output traceReady
    );

endinterface

// File: rtl/commit_trace_controller_trace_fifo.sv
// Multi-push, single-pop circular trace buffer.
// Head is read straight from the array and forced to zero when empty.
module commit_trace_controller_trace_fifo
    import commit_trace_controller_pkg::*;
#(
    parameter int PUSH_WIDTH = DEFAULT_COMMIT_WIDTH,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] push_cnt_i,
    input  TraceRecord       push_data_i [PUSH_WIDTH],
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output TraceRecord       head_o
);

    TraceRecord       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + push_cnt_i[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + push_cnt_i - CNT_W'(pop_i);
    end

    // Pushed records occupy consecutive slots starting at the write pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (CNT_W'(i) < push_cnt_i) begin
                mem_q[wr_ptr_q + PTR_W'(i)] <= push_data_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/commit_trace_controller.sv
// Commit trace capture: FSM, lane compaction, drop accounting, sequencing.
// Eligible lanes are packed into the FIFO; the excess is counted as dropped.
module commit_trace_controller
    import commit_trace_controller_pkg::*;
#(
    parameter int COMMIT_WIDTH = DEFAULT_COMMIT_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int HIGH_WATERMARK = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      traceEnable,
    input  logic                      clearStatus,
    input  logic [COMMIT_WIDTH-1:0]   commit,
    input  logic [COMMIT_WIDTH-1:0]   flush,
    input  CommitTraceEntry           commitEntry [COMMIT_WIDTH],
    commit_trace_controller_if.master trace,
    output logic                      stallReq,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] dropCount,
    output logic                      busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    TraceCtrlState state_q, state_d;
    logic [TRACE_SEQ_WIDTH-1:0] seq_q, seq_d;
    logic [DROP_CNT_WIDTH-1:0]  drop_q, drop_d;
    logic ovf_q, ovf_d;
    logic stall_q, stall_d;
    logic busy_q, busy_d;

    logic [CNT_W-1:0] count, space, push_cnt, drop_cnt, cnt_next;
    logic [DROP_CNT_WIDTH-1:0] drop_base;
    logic [DROP_CNT_WIDTH:0]   drop_sum;
    TraceRecord push_data [COMMIT_WIDTH];
    TraceRecord head;
    logic pop, capture;

    assign capture = (state_q == TRACE_CAPTURE);
    assign pop = trace.traceValid & trace.traceReady;

    commit_trace_controller_trace_fifo #(
        .PUSH_WIDTH(COMMIT_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_cnt_i (push_cnt),
        .push_data_i(push_data),
        .pop_i      (pop),
        .count_o    (count),
        .head_o     (head)
    );

    // Space ignores a same-cycle pop so a full FIFO drops every lane.
    always_comb begin
        int rank;
        rank = 0;
        drop_cnt = '0;
        space = CNT_W'(FIFO_DEPTH) - count;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            push_data[j].traceSeq = seq_q + TRACE_SEQ_WIDTH'(j);
            push_data[j].entry = '0;
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (capture && commit[i] && !flush[i]) begin
                if (CNT_W'(rank) < space) begin
                    for (int j = 0; j < COMMIT_WIDTH; j++) begin
                        if (j == rank) begin
                            push_data[j].entry = commitEntry[i];
                        end
                    end
                    rank++;
                end else begin
                    drop_cnt = drop_cnt + CNT_W'(1);
                end
            end
        end
        push_cnt = CNT_W'(rank);
    end

    always_comb begin
        cnt_next = count + push_cnt - CNT_W'(pop);
        stall_d = (cnt_next >= CNT_W'(HIGH_WATERMARK));
        seq_d = seq_q + TRACE_SEQ_WIDTH'(push_cnt);
    end

    // A drop in the clearing cycle restarts the count from zero.
    always_comb begin
        drop_d = drop_q;
        ovf_d = ovf_q;
        drop_base = clearStatus ? '0 : drop_q;
        drop_sum = {1'b0, drop_base} + (DROP_CNT_WIDTH + 1)'(drop_cnt);
        if (drop_cnt != '0) begin
            drop_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
            ovf_d = 1'b1;
        end else if (clearStatus) begin
            drop_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TRACE_DISABLED: if (traceEnable) state_d = TRACE_CAPTURE;
            TRACE_CAPTURE:  if (!traceEnable) state_d = TRACE_DRAIN;
            TRACE_DRAIN: begin
                if (traceEnable) state_d = TRACE_CAPTURE;
                else if (count == '0) state_d = TRACE_DISABLED;
            end
            default: state_d = TRACE_DISABLED;
        endcase
        busy_d = (state_d != TRACE_DISABLED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TRACE_DISABLED;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
        end
    end

    assign trace.traceValid = (count != '0);
    assign trace.traceData  = head;
    assign stallReq  = stall_q;
    assign overflow  = ovf_q;
    assign dropCount = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_commit_trace_controller.sv
// Random-stimulus bench for commit_trace_controller.
// A queue-based reference model feeds a scoreboard checked by a monitor.
module tb_commit_trace_controller;
    import commit_trace_controller_pkg::*;

    localparam int CW = 2;
    localparam int DEPTH = 16;
    localparam int HWM = 12;

    logic clk = 1'b0;
    logic rst;
    logic traceEnable, clearStatus;
    logic [CW-1:0] commit, flush;
    CommitTraceEntry commitEntry [CW];
    logic stallReq, overflow, busy;
    logic [15:0] dropCount;

    commit_trace_controller_if tif ();

    commit_trace_controller #(
        .COMMIT_WIDTH  (CW),
        .FIFO_DEPTH    (DEPTH),
        .HIGH_WATERMARK(HWM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .traceEnable(traceEnable),
        .clearStatus(clearStatus),
        .commit     (commit),
        .flush      (flush),
        .commitEntry(commitEntry),
        .trace      (tif.master),
        .stallReq   (stallReq),
        .overflow   (overflow),
        .dropCount  (dropCount),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    TraceRecord sb [$];
    int occ;
    TraceCtrlState mst;
    logic [15:0] mseq, mdrop;
    bit movf, mstall, mbusy;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        occ = 0;
        mst = TRACE_DISABLED;
        mseq = '0;
        mdrop = '0;
        movf = 0;
        mstall = 0;
        mbusy = 0;
    endtask

    // Monitor: every accepted head must match the oldest expected record.
    always @(negedge clk) begin
        TraceRecord e;
        if (rst === 1'b1 && tif.traceValid === 1'b1 && tif.traceReady === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h, want none", tif.traceData);
            end else begin
                e = sb.pop_front();
                chk("traceData", 128'(tif.traceData), 128'(e));
            end
        end
    end

    // Called at posedge+1: check last cycle's status, drive, advance model.
    task automatic step(bit en, bit clr, int p_commit, int p_flush, int p_ready);
        bit pop, was_empty;
        int pushed, dropped, nd;
        logic [63:0] r;
        TraceRecord e;
        chk("stallReq", 128'(stallReq), 128'(mstall));
        chk("overflow", 128'(overflow), 128'(movf));
        chk("dropCount", 128'(dropCount), 128'(mdrop));
        chk("busy", 128'(busy), 128'(mbusy));
        chk("traceValid", 128'(tif.traceValid), 128'(occ > 0));

        traceEnable = en;
        clearStatus = clr;
        tif.traceReady = ($urandom_range(99) < p_ready);
        for (int l = 0; l < CW; l++) begin
            commit[l] = ($urandom_range(99) < p_commit);
            flush[l] = ($urandom_range(99) < p_flush);
            r = {$urandom, $urandom};
            commitEntry[l] = r[$bits(CommitTraceEntry)-1:0];
        end

        was_empty = (occ == 0);
        pop = (occ > 0) && tif.traceReady;
        pushed = 0;
        dropped = 0;
        if (mst == TRACE_CAPTURE) begin
            for (int l = 0; l < CW; l++) begin
                if (commit[l] && !flush[l]) begin
                    if (occ + pushed < DEPTH) begin
                        e.traceSeq = mseq;
                        e.entry = commitEntry[l];
                        sb.push_back(e);
                        mseq = mseq + 16'd1;
                        pushed++;
                    end else begin
                        dropped++;
                    end
                end
            end
        end
        occ = occ + pushed - (pop ? 1 : 0);
        if (dropped > 0) begin
            nd = (clr ? 0 : int'(mdrop)) + dropped;
            if (nd > 65535) nd = 65535;
            mdrop = 16'(nd);
            movf = 1;
        end else if (clr) begin
            mdrop = '0;
            movf = 0;
        end
        mstall = (occ >= HWM);
        case (mst)
            TRACE_DISABLED: if (en) mst = TRACE_CAPTURE;
            TRACE_CAPTURE:  if (!en) mst = TRACE_DRAIN;
            TRACE_DRAIN: begin
                if (en) mst = TRACE_CAPTURE;
                else if (was_empty) mst = TRACE_DISABLED;
            end
            default: mst = TRACE_DISABLED;
        endcase
        mbusy = (mst != TRACE_DISABLED);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!(mst == TRACE_DISABLED && occ == 0) && k < 100) begin
            step(0, 0, 100, 0, 100);
            k++;
        end
        checks++;
        if (!(mst == TRACE_DISABLED && occ == 0)) begin
            errors++;
            $display("FAIL drain_timeout: got occ=%0d, want 0", occ);
        end
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit en;
        rst = 1'b0;
        traceEnable = 0;
        clearStatus = 0;
        commit = '0;
        flush = '0;
        tif.traceReady = 0;
        commitEntry[0] = '0;
        commitEntry[1] = '0;
        model_reset();

        #12;
        chk("rst_traceValid", 128'(tif.traceValid), 128'(0));
        chk("rst_traceData", 128'(tif.traceData), 128'(0));
        chk("rst_stallReq", 128'(stallReq), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_dropCount", 128'(dropCount), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        repeat (40) step(1, 0, 50, 20, 80);
        repeat (12) step(1, 0, 100, 0, 0);
        repeat (3) step(1, 0, 100, 0, 100);
        step(1, 1, 100, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        drain();

        en = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(9) == 0) en = ~en;
            step(en, ($urandom_range(19) == 0), 70, 25, 60);
        end
        drain();

        for (int k = 0; k < 40 && occ < 7; k++) step(1, 0, 100, 10, 0);
        chk("valid_before_reset", 128'(tif.traceValid), 128'(1));
        traceEnable = 0;
        clearStatus = 0;
        commit = '0;
        flush = '0;
        tif.traceReady = 0;
        #2 rst = 1'b0;
        #1;
        chk("async_traceValid", 128'(tif.traceValid), 128'(0));
        chk("async_traceData", 128'(tif.traceData), 128'(0));
        chk("async_busy", 128'(busy), 128'(0));
        model_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        repeat (30) step(1, 0, 60, 20, 70);
        drain();
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit_trace_controller.md
# commit_trace_controller

Captures committed ops from the commit stage into a small trace FIFO and drains them one per cycle to a debug or host consumer over a valid/ready handshake. Sits beside the commit stage and feeds the simulation/FPGA trace path. It asserts a stall request near full and counts ops dropped on overflow. A three-state control FSM sequences capture enable and drain.

## Interface
- COMMIT_WIDTH, default BasicTypes::COMMIT_WIDTH: commit lanes sampled per cycle.
- FIFO_DEPTH, default 16: trace FIFO entries; power of two, at least 2*COMMIT_WIDTH.
- HIGH_WATERMARK, default 12: occupancy at or above which stallReq asserts; must be less than FIFO_DEPTH.

Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- traceEnable  in  1  level; requests capture.
- clearStatus  in  1  one-cycle pulse; clears dropCount and overflow.
- commit  in  COMMIT_WIDTH  per-lane commit valid (cmReg.commit).
- flush  in  COMMIT_WIDTH  per-lane flush (cmReg.flush); a lane with flush=1 is never captured.
- commitEntry  in  COMMIT_WIDTH x CommitTraceEntry  per-lane {opId, pc, writeReg, logDstRegNum}.
- traceValid  out  1  head entry valid.
- traceReady  in  1  consumer accepts the head.
- traceData  out  TraceRecord  {traceSeq[15:0], CommitTraceEntry}.
- stallReq  out  1  occupancy >= HIGH_WATERMARK.
- overflow  out  1  sticky; set when any lane is dropped.
- dropCount  out  16  saturating count of dropped lanes.
- busy  out  1  FSM not in DISABLED.

## Operation
- FSM states and transitions:
  - DISABLED → CAPTURE when traceEnable=1.
  - CAPTURE → DRAIN when traceEnable=0.
  - DRAIN → CAPTURE when traceEnable=1.
  - DRAIN → DISABLED when the FIFO is empty and traceEnable=0.
- Capture happens only in CAPTURE. Eligible lane = commit & ~flush.
- Eligible lanes are pushed in ascending lane order, compacted into consecutive FIFO slots.
- Free space = FIFO_DEPTH − count. A pop in the same cycle is not credited.
- If eligible lanes exceed free space, the first `space` lanes are pushed and the rest are dropped.
  - dropCount increases by the number dropped, saturating at 16'hFFFF.
  - overflow is set.
- traceSeq is a 16-bit counter. Each pushed entry is stamped with it, and it then advances by one, wrapping to 0 after 16'hFFFF. Dropped lanes do not advance it.
- Pop: occurs when traceValid & traceReady; it is legal in every state, including DRAIN and DISABLED.
- clearStatus clears dropCount and overflow. If a drop happens in the same cycle, the set wins: the new drop count is loaded from zero.
- Leaving CAPTURE does not flush the FIFO. DISABLED with a non-empty FIFO is unreachable.
- count width is $clog2(FIFO_DEPTH+1). Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- Reset values, applied asynchronously:
  - state=DISABLED, pointers=0, count=0, traceSeq=0.
  - traceValid=0, stallReq=0, overflow=0, dropCount=0, busy=0.
  - traceData=0.
- Latency: a lane committed in cycle N drives traceData with traceValid=1 at N+1 at the earliest, when the FIFO was empty.
- FIFO is fall-through on a registered head; throughput is one pop per cycle.
- traceData is stable while traceValid=1 and traceReady=0.
- stallReq, overflow, dropCount and busy are all registered.
- stallReq reflects the count after that cycle's push and pop.
- Simultaneous push and pop on a full FIFO: the pop completes. The push sees space 0, so every eligible lane is dropped.
- traceEnable is sampled every cycle. The first capture occurs in the cycle after the FSM enters CAPTURE.
- Reset asserted mid-operation discards all contents immediately; traceValid falls without waiting for a clock edge.

## Structure
- Add to DebugTypes:
  - CommitTraceEntry struct, using OpId, PC_Path and LRegNumPath.
  - TraceRecord struct.
  - TraceCtrlState enum {TRACE_DISABLED, TRACE_CAPTURE, TRACE_DRAIN}.
  - TRACE_SEQ_WIDTH = 16.
- One sub-module, trace_fifo:
  - multi-push (up to COMMIT_WIDTH), single-pop circular buffer;
  - outputs count and head.
- The controller holds the FSM, lane compaction, drop accounting and the sequence counter.
- Add VerilatorHelper accessors for TraceRecord members so the C++ bench reads traceData.

## Test plan
- Enable, single lane 0 commit, opId.sid=5, pc=32'h1000, traceReady=1 → next cycle traceValid=1, traceSeq=0, pc=32'h1000; FIFO empty after.
- COMMIT_WIDTH=2, lane0 {commit=1, flush=1}, lane1 commit=1 sid=9 → only sid 9 traced with traceSeq=0; dropCount stays 0.
- traceReady=0, 2 lanes committing per cycle for 9 cycles, FIFO_DEPTH=16:
  - stallReq=1 once count reaches 12; count then reaches 16;
  - dropCount=2, overflow=1;
  - draining yields traceSeq 0..15 contiguous.
- Full FIFO, traceReady=1 with 2 lanes committing → one pop, dropCount +2; then clearStatus → dropCount=0, overflow=0.
- 5 entries queued, traceEnable drops → busy=1 in DRAIN; further commits ignored; after 5 pops state=DISABLED, busy=0.
- rst low asynchronously with 7 entries queued and traceValid=1 → traceValid=0 before the next edge; after release, the first capture has traceSeq=0.
